// File: rtl/operand_issue_arbiter.sv
// operand_issue_arbiter: round-robin issue of N_REQ warp slots into a one-deep operand buffer.
// Define OPISSUE_PERF_EN to build the issue/stall performance counters.
module operand_issue_arbiter #(
  parameter int W     = 32,
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*W-1:0]   req_op1,
  input  logic [N_REQ*W-1:0]   req_op2,
  input  logic [N_REQ*6-1:0]   req_opcode,
  input  logic [N_REQ-1:0]     req_is_fp,
  input  logic                 fp_busy,
  input  logic                 buf_valid,
  input  logic                 buf_consume,
  output logic                 buf_write_en,
  output logic [W-1:0]         buf_op1,
  output logic [W-1:0]         buf_op2,
  output logic [5:0]           buf_opcode,
  output logic                 buf_is_fp,
  output logic [ID_W-1:0]      issue_id,
  input  logic                 drain_req,
  output logic                 drain_ack,
  output logic [31:0]          perf_issue_cnt,
  output logic [31:0]          perf_stall_cnt
);
  typedef enum logic [1:0] {RUN, DRAIN, PAUSED} state_t;
  state_t state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d, issue_id_q, issue_id_d, gnt_idx, sel;
  logic [ID_W:0] cand;
  logic [N_REQ-1:0] elig;
  logic space, found, grant, drain_ack_q, drain_ack_d;
  assign elig  = req_valid & (~req_is_fp | {N_REQ{~fp_busy}});
  assign space = ~buf_valid | buf_consume;
  // Scan from rr_ptr upward with wrap; first eligible index wins.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + k[ID_W:0];
      cand = (cand >= (ID_W+1)'(N_REQ)) ? cand - (ID_W+1)'(N_REQ) : cand;
      if (!found && elig[cand[ID_W-1:0]]) begin
        found   = 1'b1;
        gnt_idx = cand[ID_W-1:0];
      end
    end
  end
  // A drain request suppresses grants in the same cycle it is seen.
  assign grant        = ~rst & found & space & (state_q == RUN) & ~drain_req;
  assign sel          = grant ? gnt_idx : '0;
  assign req_ready    = grant ? (N_REQ'(1) << gnt_idx) : '0;
  assign buf_write_en = grant;
  assign buf_op1      = req_op1[sel*W +: W];
  assign buf_op2      = req_op2[sel*W +: W];
  assign buf_opcode   = req_opcode[sel*6 +: 6];
  assign buf_is_fp    = req_is_fp[sel];
  assign issue_id     = issue_id_q;
  assign drain_ack    = drain_ack_q;
  always_comb begin
    rr_ptr_d    = grant ? ((gnt_idx == ID_W'(N_REQ-1)) ? '0 : gnt_idx + 1'b1) : rr_ptr_q;
    issue_id_d  = grant ? gnt_idx : issue_id_q;
    state_d     = state_q == RUN   ? (drain_req ? DRAIN : RUN) :
                  state_q == DRAIN ? (!drain_req ? RUN : space ? PAUSED : DRAIN) :
                                     (drain_req ? PAUSED : RUN);
    drain_ack_d = state_d == PAUSED;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      rr_ptr_q    <= '0;
      issue_id_q  <= '0;
      drain_ack_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      issue_id_q  <= issue_id_d;
      drain_ack_q <= drain_ack_d;
    end
  end
`ifdef OPISSUE_PERF_EN
  logic [31:0] perf_issue_q, perf_issue_d, perf_stall_q, perf_stall_d;
  always_comb begin
    perf_issue_d = perf_issue_q + {31'd0, grant};
    perf_stall_d = perf_stall_q + {31'd0, (state_q == RUN) & (|elig) & ~space};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issue_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_issue_q <= perf_issue_d;
      perf_stall_q <= perf_stall_d;
    end
  end
  assign perf_issue_cnt = perf_issue_q;
  assign perf_stall_cnt = perf_stall_q;
`else
  assign perf_issue_cnt = '0;
  assign perf_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_operand_issue_arbiter.sv
// tb_operand_issue_arbiter: directed checks of grant order, space/FP blocking, drain and reset.
module tb_operand_issue_arbiter;
  localparam int W = 32, N = 4, IDW = 2;
  logic clk = 0, rst = 1;
  logic [N-1:0] req_valid = '0, req_ready, req_is_fp = '0;
  logic [N*W-1:0] req_op1, req_op2;
  logic [N*6-1:0] req_opcode;
  logic fp_busy = 0, buf_valid = 0, buf_consume = 0, buf_write_en, buf_is_fp;
  logic [W-1:0] buf_op1, buf_op2;
  logic [5:0] buf_opcode;
  logic [IDW-1:0] issue_id;
  logic drain_req = 0, drain_ack;
  logic [31:0] perf_issue_cnt, perf_stall_cnt;
  int tests = 0, fails = 0;
`ifdef OPISSUE_PERF_EN
  localparam logic [31:0] EXP_ISS = 5, EXP_STL = 3;
`else
  localparam logic [31:0] EXP_ISS = 0, EXP_STL = 0;
`endif
  operand_issue_arbiter #(.W(W), .N_REQ(N)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2), .req_opcode(req_opcode), .req_is_fp(req_is_fp),
    .fp_busy(fp_busy), .buf_valid(buf_valid), .buf_consume(buf_consume),
    .buf_write_en(buf_write_en), .buf_op1(buf_op1), .buf_op2(buf_op2),
    .buf_opcode(buf_opcode), .buf_is_fp(buf_is_fp), .issue_id(issue_id),
    .drain_req(drain_req), .drain_ack(drain_ack),
    .perf_issue_cnt(perf_issue_cnt), .perf_stall_cnt(perf_stall_cnt));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  initial begin
    for (int i = 0; i < N; i++) begin
      req_op1[i*W +: W]  = 32'h100 + i;
      req_op2[i*W +: W]  = 32'h200 + i;
      req_opcode[i*6 +: 6] = 6'(i + 1);
    end
    #1;
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_wen", 32'(buf_write_en), 0);
    chk("rst_id", 32'(issue_id), 0);
    chk("rst_ack", 32'(drain_ack), 0);
    chk("rst_piss", perf_issue_cnt, 0);
    chk("rst_pstl", perf_stall_cnt, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    // back-to-back round robin with continuous consume
    req_valid = 4'b1111; buf_valid = 1; buf_consume = 1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("rr_ready", 32'(req_ready), 32'(1 << (c % 4)));
      chk("rr_op1", buf_op1, 32'h100 + 32'(c % 4));
      chk("rr_id", 32'(issue_id), c == 0 ? 0 : 32'((c - 1) % 4));
      @(negedge clk);
    end
    chk("rr_id_last", 32'(issue_id), 0);
    // buffer full blocks req 2 until consume
    req_valid = 4'b0100; buf_consume = 0;
    for (int c = 0; c < 3; c++) begin
      #1 chk("full_ready", 32'(req_ready), 0);
      @(negedge clk);
    end
    chk("perf_issue", perf_issue_cnt, EXP_ISS);
    chk("perf_stall", perf_stall_cnt, EXP_STL);
    buf_consume = 1;
    #1 chk("consume_ready", 32'(req_ready), 32'h4);
    chk("consume_opc", 32'(buf_opcode), 3);
    @(negedge clk);
    // wrap: rr_ptr=3, reqs 0 and 3
    req_valid = 4'b1001; buf_valid = 0; buf_consume = 0;
    #1 chk("wrap_r3", 32'(req_ready), 32'h8);
    @(negedge clk);
    #1 chk("wrap_r0", 32'(req_ready), 32'h1);
    chk("wrap_id3", 32'(issue_id), 3);
    @(negedge clk);
    chk("wrap_id0", 32'(issue_id), 0);
    // FP blocking does not stall integer req 2
    req_valid = 4'b0110; req_is_fp = 4'b0010; fp_busy = 1;
    #1 chk("fp_int", 32'(req_ready), 32'h4);
    chk("fp_int_op2", buf_op2, 32'h202);
    @(negedge clk);
    req_valid = 4'b0010;
    #1 chk("fp_block", 32'(req_ready), 0);
    fp_busy = 0;
    #1 chk("fp_go", 32'(req_ready), 32'h2);
    chk("fp_flag", 32'(buf_is_fp), 1);
    @(negedge clk);
    req_is_fp = 0;
    // drain with full buffer
    req_valid = 4'b0001; buf_valid = 1; drain_req = 1;
    #1 chk("drain_sup", 32'(req_ready), 0);
    @(negedge clk);
    chk("drain_ack0", 32'(drain_ack), 0);
    buf_consume = 1;
    #1 chk("drain_nog", 32'(req_ready), 0);
    @(negedge clk);
    buf_valid = 0; buf_consume = 0;
    #1 chk("paused_ack", 32'(drain_ack), 1);
    chk("paused_nog", 32'(req_ready), 0);
    drain_req = 0;
    #1 chk("paused_hold", 32'(req_ready), 0);
    @(negedge clk);
    #1 chk("resume_ack", 32'(drain_ack), 0);
    chk("resume_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    // drain abandoned before buffer empties
    req_valid = 0; buf_valid = 1; drain_req = 1;
    @(negedge clk);
    drain_req = 0;
    #1 chk("abort_ack", 32'(drain_ack), 0);
    @(negedge clk);
    buf_valid = 0; req_valid = 4'b0010;
    #1 chk("abort_run", 32'(req_ready), 32'h2);
    // mid-stream asynchronous reset
    req_valid = 4'b1111;
    repeat (2) @(negedge clk);
    rst = 1;
    #1 chk("mrst_ready", 32'(req_ready), 0);
    chk("mrst_wen", 32'(buf_write_en), 0);
    chk("mrst_id", 32'(issue_id), 0);
    chk("mrst_piss", perf_issue_cnt, 0);
    chk("mrst_pstl", perf_stall_cnt, 0);
    @(negedge clk);
    rst = 0;
    #1 chk("mrst_grant0", 32'(req_ready), 32'h1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/operand_issue_arbiter.md
# operand_issue_arbiter

Round-robin issue arbiter that shares the SM core's single one-deep operand buffer among `N_REQ` warp-slot requesters. It grants at most one requester per cycle, drives the buffer's write port and watches its valid/consume pair. It blocks FP operations while the FP pipe is busy and provides a drain/pause handshake for the warp scheduler. It sits between the warp issue slots and the operand buffer feeding the CUDA-core ALU/FPU.

## Interface
- `W`, 32, operand width
- `N_REQ`, 4, number of requesters (2..16)
- `ID_W`, `$clog2(N_REQ)`, requester index width

- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `req_valid`  in  N_REQ  per-requester operation valid
- `req_ready`  out  N_REQ  one-hot grant; transfer when `req_valid[i] & req_ready[i]`
- `req_op1`, `req_op2`  in  N_REQ*W  packed operands; requester i at `[i*W +: W]`
- `req_opcode`  in  N_REQ*6  packed opcodes
- `req_is_fp`  in  N_REQ  FP-operation flag
- `fp_busy`  in  1  FP pipe cannot accept a new FP op
- `buf_valid`  in  1  operand buffer occupied
- `buf_consume`  in  1  downstream consuming buffer this cycle
- `buf_write_en`  out  1  write strobe to buffer
- `buf_op1`, `buf_op2`  out  W  muxed operands of granted requester
- `buf_opcode`  out  6  muxed opcode
- `buf_is_fp`  out  1  muxed FP flag
- `issue_id`  out  ID_W  index of requester whose op now occupies the buffer
- `drain_req`  in  1  scheduler asks to stop issuing
- `drain_ack`  out  1  arbiter idle and buffer empty
- `perf_issue_cnt`  out  32  issued-op counter
- `perf_stall_cnt`  out  32  space-stall cycle counter

## Operation
- Eligibility: `elig[i] = req_valid[i] & (~req_is_fp[i] | ~fp_busy)`.
- Space: `space = ~buf_valid | buf_consume`. The buffer gives write priority over consume, so write+consume in the same cycle is a legal back-to-back transfer.
- Grant: only in state RUN and only with `space`. The first eligible index at or after `rr_ptr`, searched ascending with wrap to 0. At most one `req_ready` bit is high. `buf_write_en = |req_ready`.
- On grant of i: `rr_ptr <= (i+1) mod N_REQ` (wraps from N_REQ-1 to 0), and `issue_id <= i`. With no grant, `rr_ptr` and `issue_id` hold.
- `buf_*` data outputs follow the mux of the granted index. They are don't-care when `buf_write_en=0` and are driven from index 0 then.
- FSM:
  - RUN: normal grants. `drain_req=1` -> DRAIN. A grant in that same cycle is still suppressed.
  - DRAIN: no grants. When `~buf_valid` (or `buf_valid & buf_consume`), go to PAUSED.
  - PAUSED: no grants, `drain_ack=1`. `drain_req=0` -> RUN.
  - Deasserting `drain_req` while in DRAIN returns to RUN.
- Reset values: state RUN, `rr_ptr=0`, `issue_id=0`, `drain_ack=0`, `req_ready=0`, `buf_write_en=0`, both counters 0. Reset mid-transfer is abandoned; no partial state survives.

## Timing
- Grant path is combinational, `req_valid` -> `req_ready`/`buf_write_en` in the same cycle. The buffer captures data on that edge and shows `valid_out` the next cycle.
- `issue_id`, `rr_ptr`, state and `drain_ack` are registered, updating the edge after the grant or event.
- Sustained throughput is 1 op/cycle when downstream asserts `buf_consume` every cycle.
- `fp_busy` is sampled combinationally. An FP requester blocked by it does not stall later integer requesters.
- DRAIN->PAUSED takes at least 1 cycle. `drain_ack` rises the cycle after the buffer is observed empty.

## Configuration
- `OPISSUE_PERF_EN` defined:
  - `perf_issue_cnt` increments on each cycle with `buf_write_en`.
  - `perf_stall_cnt` increments on each RUN cycle with `|elig & ~space`.
  - Both wrap at 2^32 and reset to 0.
- Not defined: both counter ports are tied to 0 and no counter flops are built.

## Test plan
- Four requesters all valid, integer, `buf_consume=1` every cycle -> grants 0,1,2,3,0 in consecutive cycles; `issue_id` follows one cycle later.
- `buf_valid=1`, `buf_consume=0`, req 2 valid -> `req_ready=0`. Raise `buf_consume` -> req 2 granted that cycle.
- `rr_ptr=3`, only req 0 and req 3 valid, space -> req 3 granted, then req 0 (wrap).
- Req 1 FP, req 2 integer, `fp_busy=1` -> req 2 granted, req 1 waits. Drop `fp_busy` -> req 1 granted.
- `drain_req=1` with buffer full -> no grants. Consume -> next cycle `drain_ack=1`. Drop `drain_req` -> RUN, grants resume.
- With `OPISSUE_PERF_EN`: 5 issues and 3 space-stall cycles -> counters read 5 and 3. Assert `rst` mid-stream -> all outputs return to reset values.
